div_n_ctrl: RTL and testbench

- Runtime controller for the team's integer clock divider.
- Accepts divide-ratio updates over a valid/ready config port and holds each change until the current output period ends, so the divided output never glitches or truncates a period.
- Starts and stops the divided output cleanly at period boundaries.
- Sits between the register/config logic and any logic clocked or enabled by the divided output.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_n_ctrl_if.sv | 25 ++
 rtl/div_core.sv | 63 ++++++
 rtl/div_n_ctrl.sv | 129 ++++++++++++
 tb/tb_div_n_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the runtime clock-divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } div_state_e;

  localparam int unsigned DIV_MIN   = 2;
  // Widest ratio field the helper below supports.
  localparam int unsigned DIV_W_MAX = 16;

  // ceil(n/2) without a carry bit: (n>>1) + lsb.
  function automatic logic [DIV_W_MAX-1:0] half_hi(input logic [DIV_W_MAX-1:0] n);
    return (n >> 1) + {{(DIV_W_MAX-1){1'b0}}, n[0]};
  endfunction

endpackage

// File: rtl/div_n_ctrl_if.sv
// Config port of the divider controller: valid/ready ratio offer plus error pulse.
interface div_n_ctrl_if #(
  parameter int unsigned DIV_W = 8
);

  logic             cfg_valid_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic             cfg_ready_o;
  logic             cfg_err_o;

  modport master (
    output cfg_valid_i,
    output cfg_div_i,
    input  cfg_ready_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_div_i,
    output cfg_ready_o,
    output cfg_err_o
  );

endinterface

// File: rtl/div_core.sv
// Period counter: generates the registered divided clock and the last-cycle tick
// for ratio i_div; i_start restarts a period at cnt=0, i_stop parks the output low.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clkdiv,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_act;
  logic             r_clkdiv;
  logic             r_tick;

  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_nxt;

  assign w_half = DIV_W'(half_hi(DIV_W_MAX'(i_div)));
  assign w_last = i_div - DIV_W'(1);

  always_comb begin
    w_nxt = r_cnt + DIV_W'(1);
    if (r_cnt == w_last) begin
      w_nxt = '0;
    end
  end

  // Outputs are computed from the next count so they line up with r_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_act    <= 1'b0;
      r_clkdiv <= 1'b0;
      r_tick   <= 1'b0;
    end else if (i_stop) begin
      r_cnt    <= '0;
      r_act    <= 1'b0;
      r_clkdiv <= 1'b0;
      r_tick   <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_act    <= 1'b1;
      r_clkdiv <= 1'b1;
      r_tick   <= 1'b0;
    end else if (r_act) begin
      r_cnt    <= w_nxt;
      r_clkdiv <= (w_nxt < w_half);
      r_tick   <= (w_nxt == w_last);
    end
  end

  assign o_clkdiv = r_clkdiv;
  assign o_tick   = r_tick;

endmodule

// File: rtl/div_n_ctrl.sv
// Runtime controller for the integer clock divider: accepts ratio updates and
// run/stop requests, applying both only at output period boundaries.
module div_n_ctrl
  import div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  div_n_ctrl_if.slave      cfg,
  output logic             clkdiv_o,
  output logic             tick_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic             busy_o
);

  div_state_e       r_state;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend;
  logic             r_ready;
  logic             r_err;
  logic             r_busy;

  logic             w_xfer;
  logic             w_legal;
  logic             w_tick;
  logic             w_clkdiv;
  logic             w_start;
  logic             w_stop;

  assign w_xfer  = cfg.cfg_valid_i && r_ready;
  assign w_legal = (cfg.cfg_div_i >= DIV_W'(DIV_MIN));

  // w_tick marks the boundary cycle; decisions take effect on its closing edge.
  always_comb begin
    w_start = 1'b0;
    w_stop  = 1'b0;
    unique case (r_state)
      IDLE: w_start = en_i;
      RUN, PEND: begin
        if (w_tick) begin
          w_start = en_i;
          w_stop  = !en_i;
        end
      end
      default: begin
        w_start = 1'b0;
        w_stop  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cur_div <= DIV_W'(DEFAULT_DIV);
      r_pend    <= '0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_err <= w_xfer && !w_legal;
      unique case (r_state)
        IDLE: begin
          if (w_xfer && w_legal) begin
            r_cur_div <= cfg.cfg_div_i;
          end
          if (en_i) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          // A legal offer arriving as we stop lands directly in cur_div.
          if (w_tick && !en_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_xfer && w_legal) begin
              r_cur_div <= cfg.cfg_div_i;
            end
          end else if (w_xfer && w_legal) begin
            r_pend  <= cfg.cfg_div_i;
            r_state <= PEND;
            r_ready <= 1'b0;
          end
        end
        PEND: begin
          if (w_tick) begin
            r_cur_div <= r_pend;
            r_ready   <= 1'b1;
            if (en_i) begin
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_stop   (w_stop),
    .i_div    (r_cur_div),
    .o_clkdiv (w_clkdiv),
    .o_tick   (w_tick)
  );

  assign cfg.cfg_ready_o = r_ready;
  assign cfg.cfg_err_o   = r_err;
  assign clkdiv_o        = w_clkdiv;
  assign tick_o          = w_tick;
  assign cur_div_o       = r_cur_div;
  assign busy_o          = r_busy;

endmodule

// File: tb/tb_div_n_ctrl.sv
// Directed bench for div_n_ctrl: waveform shape, deferred ratio changes,
// illegal ratios, clean stop, boundary collisions and async reset.
module tb_div_n_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clkdiv;
  logic       tick;
  logic [7:0] cur_div;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  div_n_ctrl_if #(.DIV_W(8)) u_if ();

  div_n_ctrl #(
    .DIV_W       (8),
    .DEFAULT_DIV (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .cfg       (u_if),
    .clkdiv_o  (clkdiv),
    .tick_o    (tick),
    .cur_div_o (cur_div),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Checks clkdiv/tick for `cycles` cycles of a period of ratio n starting at count c0.
  task automatic run_chk(input string tag, input int n, input int cycles, input int c0);
    int c;
    c = c0;
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_clk"},  32'(clkdiv), 32'(c < (n + 1) / 2));
      check({tag, "_tick"}, 32'(tick),   32'(c == n - 1));
      c = (c + 1) % n;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    u_if.cfg_valid_i = 1'b0;
    u_if.cfg_div_i   = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_clk",   32'(clkdiv),            0);
    check("rst_tick",  32'(tick),              0);
    check("rst_cur",   32'(cur_div),           10);
    check("rst_ready", 32'(u_if.cfg_ready_o),  1);
    check("rst_busy",  32'(busy),              0);
    check("rst_err",   32'(u_if.cfg_err_o),    0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start at N=10: first high cycle one clock after en is sampled.
    check("idle_clk", 32'(clkdiv), 0);
    en = 1'b1;
    @(negedge clk);
    check("start_busy", 32'(busy), 1);
    run_chk("n10", 10, 20, 0);
    check("n10_cur", 32'(cur_div), 10);

    // Deferred change to 4 offered at cnt=2.
    run_chk("n10b", 10, 2, 0);
    check("defer_ready0", 32'(u_if.cfg_ready_o), 1);
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd4;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b0;
    check("defer_ready_pend", 32'(u_if.cfg_ready_o), 0);
    check("defer_cur_old",    32'(cur_div),          10);
    check("defer_busy",       32'(busy),             1);
    run_chk("defer", 10, 6, 3);
    check("defer_ready_bnd", 32'(u_if.cfg_ready_o), 0);
    check("defer_cur_bnd",   32'(cur_div),          10);
    run_chk("defer_last", 10, 1, 9);
    check("defer_cur_new",   32'(cur_div),          4);
    check("defer_ready_new", 32'(u_if.cfg_ready_o), 1);
    run_chk("n4", 4, 8, 0);

    // Illegal ratios 1 then 0, back to back.
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd1;
    @(negedge clk);
    check("ill1_err",   32'(u_if.cfg_err_o),   1);
    check("ill1_cur",   32'(cur_div),          4);
    check("ill1_clk",   32'(clkdiv),           1);
    check("ill1_ready", 32'(u_if.cfg_ready_o), 1);
    u_if.cfg_div_i = 8'd0;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b0;
    check("ill0_err",   32'(u_if.cfg_err_o),   1);
    check("ill0_clk",   32'(clkdiv),           0);
    check("ill0_ready", 32'(u_if.cfg_ready_o), 1);
    @(negedge clk);
    check("ill_err_clr", 32'(u_if.cfg_err_o), 0);
    check("ill_cur",     32'(cur_div),        4);
    run_chk("ill_tail", 4, 1, 3);

    // Odd ratio 3.
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd3;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b0;
    run_chk("to3", 4, 3, 1);
    check("n3_cur", 32'(cur_div), 3);
    run_chk("n3", 3, 6, 0);

    // Clean stop at N=6: en dropped at cnt=1.
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd6;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b0;
    run_chk("to6", 3, 2, 1);
    check("n6_cur", 32'(cur_div), 6);
    run_chk("n6", 6, 1, 0);
    en = 1'b0;
    run_chk("stop6", 6, 5, 1);
    check("stop_clk",   32'(clkdiv),           0);
    check("stop_busy",  32'(busy),             0);
    check("stop_tick",  32'(tick),             0);
    check("stop_ready", 32'(u_if.cfg_ready_o), 1);
    @(negedge clk);
    check("stop_clk2", 32'(clkdiv), 0);

    // Pending 8 meets stop at the same boundary.
    en = 1'b1;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd8;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b0;
    run_chk("ps_a", 6, 1, 1);
    en = 1'b0;
    run_chk("ps_b", 6, 4, 2);
    check("ps_cur",   32'(cur_div),           8);
    check("ps_busy",  32'(busy),              0);
    check("ps_clk",   32'(clkdiv),            0);
    check("ps_ready", 32'(u_if.cfg_ready_o),  1);
    en = 1'b1;
    @(negedge clk);
    run_chk("n8", 8, 16, 0);

    // Offer on a tick cycle waits for the following boundary.
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd6;
    @(negedge clk);
    u_if.cfg_valid_i = 1'b0;
    run_chk("to6b", 8, 7, 1);
    check("n6b_cur", 32'(cur_div), 6);
    run_chk("n6b", 6, 5, 0);
    check("col_ready", 32'(u_if.cfg_ready_o), 1);
    u_if.cfg_valid_i = 1'b1;
    u_if.cfg_div_i   = 8'd8;
    run_chk("col_tick", 6, 1, 5);
    u_if.cfg_valid_i = 1'b0;
    check("col_cur_held", 32'(cur_div),          6);
    check("col_ready0",   32'(u_if.cfg_ready_o), 0);
    run_chk("col_old", 6, 6, 0);
    check("col_cur_new", 32'(cur_div),          8);
    check("col_ready1",  32'(u_if.cfg_ready_o), 1);
    run_chk("col_new", 8, 2, 0);

    // Async reset mid-period while high.
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_clk",   32'(clkdiv),           0);
    check("arst_cur",   32'(cur_div),          10);
    check("arst_ready", 32'(u_if.cfg_ready_o), 1);
    check("arst_busy",  32'(busy),             0);
    check("arst_tick",  32'(tick),             0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_busy", 32'(busy),   0);
    check("post_clk",  32'(clkdiv), 0);
    en = 1'b1;
    @(negedge clk);
    run_chk("post_n10", 10, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
